// File: rtl/serial_add_ctrl.sv
`timescale 1ns/1ps
// Bit-serial add/subtract controller: one full_add cell reused over WIDTH cycles, LSB first,
// with valid/ready handshakes on the operand and result sides.

module full_add (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_out_valid;

  logic w_s;
  logic w_co;
  logic w_last;
  logic w_accept;

  full_add u_full_add (
    .s  (w_s),
    .co (w_co),
    .a  (r_a_sr[0]),
    .b  (r_b_sr[0]),
    .ci (r_carry)
  );

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  // Abort blocks acceptance even while idle.
  assign w_accept = i_in_valid & r_in_ready & ~i_abort;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_sum_sr    <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a_sr     <= i_a;
            r_b_sr     <= i_b ^ {WIDTH{i_sub}};
            r_carry    <= i_sub;
            r_cnt      <= '0;
            r_sum_sr   <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_ADD;
          end
        end
        ST_ADD: begin
          if (i_abort) begin
            r_a_sr     <= '0;
            r_b_sr     <= '0;
            r_sum_sr   <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_carry  <= w_co;
            if (w_last) begin
              // r_carry here is the carry into the MSB, so ovf compares it with carry out.
              r_cout      <= w_co;
              r_ovf       <= r_carry ^ w_co;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_DONE: begin
          if (i_abort) begin
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_sum_sr    <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_busy      = r_busy;
  assign o_out_valid = r_out_valid;
  assign o_sum       = r_sum_sr;
  assign o_cout      = r_cout;
  assign o_ovf       = r_ovf;

endmodule
